// File: rtl/id_imm_stage.sv
// Decode stage: classifies opcodes into immediate extension modes and
// owns the ID/EX register with load-use bubble insertion and flush.
module id_imm_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_opcode,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [1:0]       out_ext_mode,
  output logic             out_illegal,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EXT_NONE  = 2'd0,
    EXT_SIGN  = 2'd1,
    EXT_ZERO  = 2'd2,
    EXT_UPPER = 2'd3
  } ext_e;

  logic [5:0]  opc;
  logic [15:0] imm16;
  ext_e        mode_d;
  logic        illegal_d;
  logic        rt_read;
  logic [31:0] imm_d;
  logic        hazard;
  logic        advance;

  assign opc   = in_instr[31:26];
  assign imm16 = in_instr[15:0];

  always_comb begin
    mode_d    = EXT_SIGN;
    illegal_d = 1'b0;
    rt_read   = 1'b0;
    unique case (opc)
      6'h04, 6'h05, 6'h2B: begin
        mode_d  = EXT_SIGN;
        rt_read = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h23:
        mode_d = EXT_SIGN;
      6'h0C, 6'h0D, 6'h0E:
        mode_d = EXT_ZERO;
      6'h0F:
        mode_d = EXT_UPPER;
      6'h00: begin
        mode_d  = EXT_NONE;
        rt_read = 1'b1;
      end
      6'h02:
        mode_d = EXT_NONE;
      default:
        illegal_d = 1'b1;
    endcase
  end

  always_comb begin
    imm_d = 32'h0;
    unique case (mode_d)
      EXT_SIGN:  imm_d = {{16{imm16[15]}}, imm16};
      EXT_ZERO:  imm_d = {16'h0, imm16};
      EXT_UPPER: imm_d = {imm16, 16'h0};
      default:   imm_d = 32'h0;
    endcase
  end

  assign hazard = in_valid & ex_valid & ex_mem_read
                & (ex_rt != 5'd0)
                & ((ex_rt == in_instr[25:21])
                 | (rt_read & (ex_rt == in_instr[20:16])));

  logic             valid_q;
  logic [5:0]       opcode_q;
  logic [4:0]       rs_q;
  logic [4:0]       rt_q;
  logic [4:0]       rd_q;
  logic [31:0]      imm_q;
  ext_e             mode_q;
  logic             illegal_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] cnt_q;

  assign advance  = ~valid_q | out_ready;
  assign in_ready = flush | (advance & ~hazard);

  // Priority: flush, then EX back-pressure hold, then bubble, then load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      mode_q    <= EXT_NONE;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      cnt_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!advance) begin
      valid_q <= valid_q;
    end else if (hazard) begin
      valid_q <= 1'b0;
      if (!(&cnt_q))
        cnt_q <= cnt_q + CNT_W'(1);
    end else if (in_valid) begin
      valid_q   <= 1'b1;
      opcode_q  <= opc;
      rs_q      <= in_instr[25:21];
      rt_q      <= in_instr[20:16];
      rd_q      <= in_instr[15:11];
      imm_q     <= imm_d;
      mode_q    <= mode_d;
      illegal_q <= illegal_d;
      pc_q      <= in_pc;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid    = valid_q;
  assign out_opcode   = opcode_q;
  assign out_rs       = rs_q;
  assign out_rt       = rt_q;
  assign out_rd       = rd_q;
  assign out_imm      = imm_q;
  assign out_ext_mode = mode_q;
  assign out_illegal  = illegal_q;
  assign out_pc       = pc_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_imm_stage.sv
// Bench for id_imm_stage: reference model plus directed vectors.
module tb_id_imm_stage;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             in_ready;
  logic             flush;
  logic             ex_valid;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             out_valid;
  logic             out_ready;
  logic [5:0]       out_opcode;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [31:0]      out_imm;
  logic [1:0]       out_ext_mode;
  logic             out_illegal;
  logic [31:0]      out_pc;
  logic [CNT_W-1:0] stall_cnt;

  id_imm_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_imm(out_imm), .out_ext_mode(out_ext_mode),
    .out_illegal(out_illegal), .out_pc(out_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nfail   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference rules written directly from the opcode tables.
  function automatic logic is_known(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09,
                      6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
  endfunction

  function automatic int m_mode(input logic [5:0] op);
    if (op inside {6'h00, 6'h02}) return 0;
    if (op inside {6'h0C, 6'h0D, 6'h0E}) return 2;
    if (op == 6'h0F) return 3;
    return 1;
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int unsigned v;
    v = ins[15:0];
    case (m_mode(ins[31:26]))
      0: return 32'h0;
      2: return v;
      3: return v * 65536;
      default: return (v >= 32'h8000) ? v + 32'hFFFF0000 : v;
    endcase
  endfunction

  function automatic logic m_hazard();
    logic rtr;
    rtr = in_instr[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2B};
    return in_valid && ex_valid && ex_mem_read && ex_rt != 0 &&
           (ex_rt == in_instr[25:21] || (rtr && ex_rt == in_instr[20:16]));
  endfunction

  logic        e_valid;
  logic        e_known;
  logic [31:0] e_instr;
  logic [31:0] e_pc;
  int          e_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid = 1'b0;
      e_known = 1'b1;
      e_instr = 32'h0;
      e_pc    = 32'h0;
      e_cnt   = 0;
    end else if (flush) begin
      e_valid = 1'b0;
      e_known = 1'b0;
    end else if (e_valid && !out_ready) begin
      e_valid = e_valid;
    end else if (m_hazard()) begin
      e_valid = 1'b0;
      e_known = 1'b0;
      if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
    end else if (in_valid) begin
      e_valid = 1'b1;
      e_known = 1'b1;
      e_instr = in_instr;
      e_pc    = in_pc;
    end else begin
      e_valid = 1'b0;
      e_known = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic exp_rdy;
    exp_rdy = flush || ((!e_valid || out_ready) && !m_hazard());
    chk("m_valid", 32'(out_valid), 32'(e_valid));
    chk("m_cnt", 32'(stall_cnt), e_cnt);
    chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
    if (e_known && e_valid) begin
      chk("m_opcode", 32'(out_opcode), 32'(e_instr[31:26]));
      chk("m_rs", 32'(out_rs), 32'(e_instr[25:21]));
      chk("m_rt", 32'(out_rt), 32'(e_instr[20:16]));
      chk("m_rd", 32'(out_rd), 32'(e_instr[15:11]));
      chk("m_imm", out_imm, m_imm(e_instr));
      chk("m_mode", 32'(out_ext_mode), m_mode(e_instr[31:26]));
      chk("m_illegal", 32'(out_illegal), 32'(!is_known(e_instr[31:26])));
      chk("m_pc", out_pc, e_pc);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    in_valid = v;
    in_instr = ins;
    in_pc    = in_pc + 32'd4;
  endtask

  task automatic set_ex(input logic v, input logic mr, input logic [4:0] rt);
    ex_valid    = v;
    ex_mem_read = mr;
    ex_rt       = rt;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_pc = 32'h1000;
    flush = 1'b0;
    out_ready = 1'b1;
    set_ex(1'b0, 1'b0, 5'd0);
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    drive(1'b1, 32'h2008FFFF);
    step();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_mode", 32'(out_ext_mode), 32'd1);
    drive(1'b1, 32'h3508FFFF);
    step();
    chk("ori_imm", out_imm, 32'h0000FFFF);
    chk("ori_mode", 32'(out_ext_mode), 32'd2);
    drive(1'b1, 32'h3C081234);
    step();
    chk("lui_imm", out_imm, 32'h12340000);
    chk("lui_mode", 32'(out_ext_mode), 32'd3);
    drive(1'b1, 32'h010A4820);
    step();
    chk("add_imm", out_imm, 32'h0);
    chk("add_mode", 32'(out_ext_mode), 32'd0);
    chk("add_rd", 32'(out_rd), 32'd9);
    drive(1'b1, 32'hFC001234);
    step();
    chk("ill_flag", 32'(out_illegal), 32'd1);
    chk("ill_imm", out_imm, 32'h00001234);

    set_ex(1'b1, 1'b1, 5'd8);
    drive(1'b1, 32'h010A4820);
    #1 chk("lu_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("lu_bubble", 32'(out_valid), 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    ex_mem_read = 1'b0;
    #1 chk("lu_release", 32'(in_ready), 32'd1);
    step();
    chk("lu_load", 32'(out_valid), 32'd1);
    chk("lu_rd", 32'(out_rd), 32'd9);
    set_ex(1'b1, 1'b1, 5'd0);
    drive(1'b1, 32'h010A4820);
    step();
    chk("r0_valid", 32'(out_valid), 32'd1);
    chk("r0_cnt", 32'(stall_cnt), 32'd1);

    set_ex(1'b1, 1'b1, 5'd8);
    drive(1'b1, 32'h20080001);
    step();
    chk("nort_valid", 32'(out_valid), 32'd1);
    drive(1'b1, 32'h10080004);
    step();
    chk("beq_bubble", 32'(out_valid), 32'd0);
    chk("beq_cnt", 32'(stall_cnt), 32'd2);
    ex_mem_read = 1'b0;
    step();
    chk("beq_imm", out_imm, 32'h4);

    set_ex(1'b0, 1'b0, 5'd0);
    drive(1'b1, 32'h34081111);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'h3C08ABCD);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_imm", out_imm, 32'h00001111);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", 32'(in_ready), 32'd1);
    step();
    chk("bp_next", out_imm, 32'hABCD0000);

    out_ready = 1'b0;
    set_ex(1'b1, 1'b1, 5'd8);
    drive(1'b1, 32'h010A4820);
    flush = 1'b1;
    #1 chk("fl_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_cnt", 32'(stall_cnt), 32'd2);
    flush = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < (1 << CNT_W); i++) step();
    chk("sat_cnt", 32'(stall_cnt), 32'hF);
    step();
    chk("sat_hold", 32'(stall_cnt), 32'hF);

    set_ex(1'b0, 1'b0, 5'd0);
    drive(1'b1, 32'h2008FFFF);
    step();
    chk("mr_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 chk("mr_clear", 32'(out_valid), 32'd0);
    chk("mr_cnt", 32'(stall_cnt), 32'd0);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/id_imm_stage.md
Name: id_imm_stage

Overview:
- Decode-stage controller that sequences the 16-to-32-bit immediate extension unit for the 5-stage MIPS pipeline.
- Sits between the IF/ID register and the EX stage.
- Classifies each opcode into an extension mode and produces the extended immediate and register fields.
- Owns the ID/EX pipeline register with a valid/ready handshake, detects load-use hazards (inserting one bubble), honours branch flushes, and counts hazard stalls.

Parameters:
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  IF/ID holds a valid instruction
- in_instr  input  32  instruction word
- in_pc  input  32  PC of instruction
- in_ready  output  1  stage accepts in_instr this cycle
- flush  input  1  kill the instruction in ID and the ID/EX contents
- ex_valid  input  1  EX stage holds a valid instruction
- ex_mem_read  input  1  EX instruction is a load
- ex_rt  input  5  destination register of the EX load
- out_valid  output  1  ID/EX register holds a valid instruction
- out_ready  input  1  EX accepts ID/EX contents
- out_opcode  output  6  instr[31:26]
- out_rs  output  5  instr[25:21]
- out_rt  output  5  instr[20:16]
- out_rd  output  5  instr[15:11]
- out_imm  output  32  extended immediate
- out_ext_mode  output  2  0=NONE, 1=SIGN, 2=ZERO, 3=UPPER
- out_illegal  output  1  opcode not recognised
- out_pc  output  32  registered in_pc
- stall_cnt  output  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, rst=1): every output register cleared to 0: out_valid, all out_* fields, stall_cnt. in_ready is combinational and therefore reads 1 while rst=1.
- Extension mode from opcode (combinational, registered into ID/EX):
  - SIGN for 0x04, 0x05, 0x08, 0x09, 0x0A, 0x23, 0x2B: imm = {{16{instr[15]}}, instr[15:0]}.
  - ZERO for 0x0C, 0x0D, 0x0E: imm = {16'b0, instr[15:0]}.
  - UPPER for 0x0F: imm = {instr[15:0], 16'b0}.
  - NONE for 0x00 and 0x02: imm = 0.
  - Any other opcode: SIGN extension with out_illegal=1.
- rt-read: opcode is 0x00, 0x04, 0x05 or 0x2B.
- hazard = in_valid & ex_valid & ex_mem_read & (ex_rt!=0) & (ex_rt==instr[25:21] | (rt-read & ex_rt==instr[20:16])).
- advance = ~out_valid | out_ready.
- in_ready = advance & ~hazard, or 1 when flush (the flushed input is consumed and discarded).
- Priority on each edge: flush > hold > hazard > load.
  - flush=1: out_valid<=0; the input is dropped; stall_cnt is unchanged.
  - ~advance: the ID/EX register holds all fields unchanged (EX back-pressure); no counting, even if hazard is set.
  - advance & hazard: bubble, out_valid<=0, other fields don't-care; stall_cnt increments unless it is all-ones.
  - advance & in_valid: load all fields, out_valid<=1.
  - advance & ~in_valid: out_valid<=0.
- Latency: one cycle from accepted input to out_valid.
- Throughput: one instruction per cycle when out_ready stays high.
- A hazard costs exactly one bubble, because the load leaves EX on the same edge the bubble enters ID/EX. The stage does not track this itself; it re-evaluates hazard every cycle from the ex_* inputs.
- Reset asserted mid-operation clears the pipeline register immediately. The in-flight instruction is lost, and upstream re-fetches it.

Test Plan:
- Reset: rst=1 for 2 cycles -> out_valid=0, stall_cnt=0, out_imm=0, in_ready=1.
- Extension modes, out_ready=1, one instruction per cycle:
  - addi 0x2008FFFF -> next cycle out_imm=0xFFFFFFFF, mode 1.
  - ori 0x3508FFFF -> out_imm=0x0000FFFF, mode 2.
  - lui 0x3C081234 -> out_imm=0x12340000, mode 3.
  - add (opcode 0) -> out_imm=0, mode 0.
  - opcode 0x3F -> out_illegal=1.
- Load-use: ex_valid=1, ex_mem_read=1, ex_rt=8, in_instr add $9,$8,$10 -> in_ready=0, next out_valid=0, stall_cnt=1. Then drop ex_mem_read -> instruction loads the following cycle. Repeat with ex_rt=0 -> no stall.
- Back-pressure: out_valid=1 with out_ready=0 for 3 cycles -> out_* stable and in_ready=0. Raise out_ready -> next instruction loads on that edge.
- Flush with hazard and out_ready=0 in the same cycle -> in_ready=1, next out_valid=0, stall_cnt unchanged.
- Saturation: preload the counter via 2^CNT_W hazards (CNT_W=4 in the bench) -> stall_cnt stays at 0xF.
